// File: rtl/reg_file_wb.sv
// Register file with a one-entry write-back latch and read bypass.
// Register 0 is hardwired to zero; reset clears the array and the latch.
module reg_file_wb #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Reg_write,
    input  logic [N-1:0] Reg_write_ad,
    input  logic [W-1:0] Reg_write_data,
    input  logic [N-1:0] rs,
    input  logic [N-1:0] rt,
    output logic [W-1:0] rs_data,
    output logic [W-1:0] rt_data,
    output logic         wb_pending
);

    localparam int DEPTH = 1 << N;

    logic [W-1:0] r_mem [DEPTH];
    logic         r_wb_valid;
    logic [N-1:0] r_wb_addr;
    logic [W-1:0] r_wb_data;

    logic         w_accept;

    // Writes to register 0 never enter the latch, so entry 0 stays zero.
    assign w_accept = Reg_write && (Reg_write_ad != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_accept;
            r_wb_addr  <= Reg_write_ad;
            r_wb_data  <= Reg_write_data;
        end
    end

    // Commit of the latched write happens on the same edge as the reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_wb_valid) begin
            r_mem[r_wb_addr] <= r_wb_data;
        end
    end

    function automatic logic [W-1:0] f_read(
        input logic [N-1:0] a,
        input logic         v,
        input logic [N-1:0] la,
        input logic [W-1:0] ld,
        input logic [W-1:0] md
    );
        logic [W-1:0] d;
        d = md;
        if (a == '0) begin
            d = '0;
        end else if (v && (la == a)) begin
            d = ld;
        end
        return d;
    endfunction

    always_comb begin
        rs_data = '0;
        rs_data = f_read(rs, r_wb_valid, r_wb_addr, r_wb_data, r_mem[rs]);
    end

    always_comb begin
        rt_data = '0;
        rt_data = f_read(rt, r_wb_valid, r_wb_addr, r_wb_data, r_mem[rt]);
    end

    assign wb_pending = r_wb_valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: bypass, commit, register 0,
// same-cycle non-bypass and asynchronous reset behaviour.
module tb_reg_file_wb;

    localparam int N = 3;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         Reg_write;
    logic [N-1:0] Reg_write_ad;
    logic [W-1:0] Reg_write_data;
    logic [N-1:0] rs;
    logic [N-1:0] rt;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         wb_pending;

    int vectors = 0;
    int miscompares = 0;

    reg_file_wb #(.N(N), .W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .Reg_write     (Reg_write),
        .Reg_write_ad  (Reg_write_ad),
        .Reg_write_data(Reg_write_data),
        .rs            (rs),
        .rt            (rt),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_pending    (wb_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [N-1:0] a, input logic [W-1:0] d);
        Reg_write      = 1'b1;
        Reg_write_ad   = a;
        Reg_write_data = d;
    endtask

    task automatic idle();
        Reg_write      = 1'b0;
        Reg_write_ad   = '0;
        Reg_write_data = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs = 3'd3;
        rt = 3'd5;
        #2;
        chk("rst_rs", rs_data, 16'h0000);
        chk("rst_rt", rt_data, 16'h0000);
        chk("rst_pend", {15'd0, wb_pending}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rs", rs_data, 16'h0000);

        // basic write then read via bypass, then via array
        @(negedge clk);
        wr(3'd3, 16'h00AA);
        rs = 3'd3;
        edge_step();
        chk("wr3_bypass", rs_data, 16'h00AA);
        chk("wr3_pend", {15'd0, wb_pending}, 16'h0001);
        idle();
        edge_step();
        chk("wr3_array", rs_data, 16'h00AA);
        chk("wr3_pend0", {15'd0, wb_pending}, 16'h0000);

        // register 0 writes are discarded
        wr(3'd0, 16'hFFFF);
        rs = 3'd0;
        rt = 3'd0;
        edge_step();
        chk("r0_rs", rs_data, 16'h0000);
        chk("r0_rt", rt_data, 16'h0000);
        chk("r0_pend", {15'd0, wb_pending}, 16'h0000);
        idle();
        edge_step();
        chk("r0_rs_after", rs_data, 16'h0000);

        // back-to-back writes to the same address
        wr(3'd7, 16'h0011);
        rs = 3'd7;
        rt = 3'd7;
        edge_step();
        chk("b2b1_rs", rs_data, 16'h0011);
        chk("b2b1_rt", rt_data, 16'h0011);
        wr(3'd7, 16'h0022);
        edge_step();
        chk("b2b2_rs", rs_data, 16'h0022);
        chk("b2b2_rt", rt_data, 16'h0022);
        idle();
        edge_step();
        chk("b2b3_rs", rs_data, 16'h0022);
        chk("b2b3_rt", rt_data, 16'h0022);
        chk("b2b3_pend", {15'd0, wb_pending}, 16'h0000);

        // different addresses back to back, both land in the array
        wr(3'd1, 16'h0101);
        edge_step();
        wr(3'd6, 16'h0606);
        rs = 3'd1;
        rt = 3'd6;
        edge_step();
        chk("diff_rs1", rs_data, 16'h0101);
        chk("diff_rt6", rt_data, 16'h0606);
        idle();
        edge_step();
        chk("diff_rs1_arr", rs_data, 16'h0101);
        chk("diff_rt6_arr", rt_data, 16'h0606);
        rs = 3'd3;
        rt = 3'd7;
        #1;
        chk("keep_r3", rs_data, 16'h00AA);
        chk("keep_r7", rt_data, 16'h0022);

        // no same-cycle bypass
        wr(3'd2, 16'h0005);
        edge_step();
        idle();
        edge_step();
        rs = 3'd2;
        rt = 3'd3;
        wr(3'd2, 16'h0009);
        #2;
        chk("nobyp_before", rs_data, 16'h0005);
        edge_step();
        chk("nobyp_after", rs_data, 16'h0009);
        chk("nobyp_rt3", rt_data, 16'h00AA);
        idle();
        edge_step();
        chk("nobyp_array", rs_data, 16'h0009);

        // reset while a write is pending in the latch
        wr(3'd4, 16'h1234);
        rs = 3'd4;
        rt = 3'd3;
        edge_step();
        chk("mid_bypass", rs_data, 16'h1234);
        idle();
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rs", rs_data, 16'h0000);
        chk("mid_rst_rt", rt_data, 16'h0000);
        chk("mid_rst_pend", {15'd0, wb_pending}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        wr(3'd5, 16'hBEEF);
        rt = 3'd5;
        edge_step();
        chk("first_edge_rt5", rt_data, 16'hBEEF);
        chk("first_edge_pend", {15'd0, wb_pending}, 16'h0001);
        chk("discard_r4", rs_data, 16'h0000);
        idle();
        edge_step();
        chk("r4_after", rs_data, 16'h0000);
        chk("r5_array", rt_data, 16'hBEEF);
        rs = 3'd2;
        #1;
        chk("r2_cleared", rs_data, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 The module SHALL have parameter N, default 3, meaning register address width (2**N registers).
REQ-002 The module SHALL have parameter W, default 16, meaning register data width.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The module SHALL have port Reg_write  input  1  write enable for the current cycle.
REQ-006 The module SHALL have port Reg_write_ad  input  N  destination register address, as produced by the write-address select stage.
REQ-007 The module SHALL have port Reg_write_data  input  W  data to write.
REQ-008 The module SHALL have port rs  input  N  read address, port A.
REQ-009 The module SHALL have port rt  input  N  read address, port B.
REQ-010 The module SHALL have port rs_data  output  W  read data, port A (combinational).
REQ-011 The module SHALL have port rt_data  output  W  read data, port B (combinational).
REQ-012 The module SHALL have port wb_pending  output  1  high while the write-back latch holds an uncommitted write.

Function
REQ-013 The module SHALL contain a 2**N x W register array and a write-back latch {wb_valid, wb_addr[N-1:0], wb_data[W-1:0]}.
REQ-014 At each rising clk, if wb_valid=1, the module SHALL commit wb_data into array[wb_addr].
REQ-015 At the same edge, the latch SHALL load wb_valid<=Reg_write & (Reg_write_ad!=0), wb_addr<=Reg_write_ad, wb_data<=Reg_write_data; commit and reload occur together, so back-to-back writes each take effect.
REQ-016 A write accepted at edge k SHALL be visible on read ports (via bypass) from edge k until edge k+1, and from the array from edge k+1 onward; write latency to the array is 2 edges.
REQ-017 Register 0 SHALL read as 0 always; writes addressed to 0 SHALL be discarded and SHALL NOT set wb_valid.
REQ-018 For each read port: if address==0 output 0; else if wb_valid=1 and wb_addr==address output wb_data; else output array[address].
REQ-019 Same-cycle inputs (Reg_write_data on a not-yet-latched write) SHALL NOT be bypassed to read ports.
REQ-020 Both read ports SHALL be independent; rs==rt SHALL give identical data on both.
REQ-021 Consecutive writes to the same address SHALL leave the later value in the array; the bypass SHALL always reflect the latch (newest) value.
REQ-022 wb_pending SHALL equal wb_valid.
REQ-023 Reg_write_ad, rs, rt SHALL be full-range; no address wrap or out-of-range case exists.

Reset
REQ-024 While rst=1, all array entries, wb_valid, wb_addr, wb_data SHALL be 0 immediately, independent of clk; rs_data=rt_data=0, wb_pending=0.
REQ-025 A write pending in the latch when rst asserts SHALL be discarded (not committed).
REQ-026 The first edge after rst deasserts SHALL behave as a normal edge (may accept a write).

Verification
REQ-027 Reset: rst=1 then 0, rs=3, rt=5 -> rs_data=0, rt_data=0, wb_pending=0.
REQ-028 Basic write/read: Reg_write=1, Reg_write_ad=3, data=0x00AA for one edge, rs=3 -> rs_data=0x00AA right after that edge (bypass, wb_pending=1) and still 0x00AA after next edge with Reg_write=0 (array, wb_pending=0).
REQ-029 Register 0: write 0xFFFF to address 0, rs=0 -> rs_data=0, wb_pending stays 0.
REQ-030 Back-to-back same address: write 7<-0x0011 then 7<-0x0022 on consecutive edges, rs=rt=7 -> both 0x0011 after first edge, both 0x0022 after second and thereafter.
REQ-031 No same-cycle bypass: array[2]=0x0005, drive Reg_write=1, Reg_write_ad=2, data=0x0009 before edge -> rs_data (rs=2) stays 0x0005 until the edge, then 0x0009.
REQ-032 Reset mid-operation: write 4<-0x1234, assert rst before next edge -> after reset rs=4 gives 0, wb_pending=0.
